// File: rtl/enemy_shot.sv
// Bullet generator for a single enemy ship. It waits fire_delay_p frames, spawns a
// bullet under the ship, moves it down once per frame, and reports player hits.
module enemy_shot #(
   parameter logic [15:0] fire_delay_p = 16'd60,
   parameter logic [9:0]  speed_p      = 10'd4,
   parameter logic [9:0]  bullet_w_p   = 10'd2,
   parameter logic [9:0]  bullet_h_p   = 10'd8,
   parameter logic [9:0]  screen_bot_p = 10'd479,
   parameter logic [11:0] color_p      = 12'hF00
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       frame_i,
   input  logic       start_i,
   input  logic       enemy_dead_i,
   input  logic [9:0] enemy_left_i,
   input  logic [9:0] enemy_right_i,
   input  logic [9:0] enemy_bot_i,
   input  logic [9:0] player_left_i,
   input  logic [9:0] player_right_i,
   input  logic [9:0] player_top_i,
   input  logic [9:0] player_bot_i,
   output logic       active_o,
   output logic [9:0] left_o,
   output logic [9:0] right_o,
   output logic [9:0] top_o,
   output logic [9:0] bot_o,
   output logic       player_hit_o,
   output logic [3:0] shot_red_o,
   output logic [3:0] shot_green_o,
   output logic [3:0] shot_blue_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'b001,
      COOLDOWN = 3'b010,
      FLYING   = 3'b100
   } state_e;

   // A zero delay behaves like a delay of one frame.
   localparam logic [15:0] term_c = (fire_delay_p == 16'd0) ? 16'd0 : fire_delay_p - 16'd1;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [9:0]  left_q, left_d;
   logic [9:0]  top_q, top_d;
   logic        hit_q, hit_d;

   logic [10:0] ship_sum;
   logic [9:0]  spawn_left;
   logic [9:0]  right_w;
   logic [9:0]  bot_w;
   logic [10:0] next_bot;
   logic        overlap;
   logic        off_screen;

   assign ship_sum   = {1'b0, enemy_left_i} + {1'b0, enemy_right_i};
   assign spawn_left = ship_sum[10:1] - (bullet_w_p >> 1);
   assign right_w    = left_q + bullet_w_p - 10'd1;
   assign bot_w      = top_q + bullet_h_p - 10'd1;

   // Bottom edge after a prospective move, kept in 11 bits so it cannot wrap.
   assign next_bot   = {1'b0, top_q} + {1'b0, speed_p} + {1'b0, bullet_h_p} - 11'd1;
   assign off_screen = next_bot > {1'b0, screen_bot_p};

   assign overlap = (left_q <= player_right_i) && (right_w >= player_left_i) &&
                    (top_q <= player_bot_i) && (bot_w >= player_top_i);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      top_d   = top_q;
      hit_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i && !enemy_dead_i) begin
               state_d = COOLDOWN;
               cnt_d   = 16'd0;
            end
         end
         COOLDOWN: begin
            if (enemy_dead_i) begin
               state_d = IDLE;
            end else if (frame_i) begin
               if (cnt_q == term_c) begin
                  state_d = FLYING;
                  cnt_d   = 16'd0;
                  left_d  = spawn_left;
                  top_d   = enemy_bot_i + 10'd1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         FLYING: begin
            if (frame_i) begin
               if (overlap || off_screen) begin
                  hit_d   = overlap;
                  cnt_d   = 16'd0;
                  state_d = enemy_dead_i ? IDLE : COOLDOWN;
               end else begin
                  top_d = top_q + speed_p;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         left_q  <= 10'd0;
         top_q   <= 10'd0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         top_q   <= top_d;
         hit_q   <= hit_d;
      end
   end

   assign active_o     = (state_q == FLYING);
   assign left_o       = left_q;
   assign top_o        = top_q;
   assign right_o      = right_w;
   assign bot_o        = bot_w;
   assign player_hit_o = hit_q;
   assign shot_red_o   = color_p[11:8];
   assign shot_green_o = color_p[7:4];
   assign shot_blue_o  = color_p[3:0];

endmodule

// File: tb/tb_enemy_shot.sv
// Directed bench for enemy_shot: spawn timing, flight, off-screen retirement,
// player hit, enemy death and asynchronous reset.
module tb_enemy_shot;

   logic       clk = 1'b0;
   logic       reset_ni;
   logic       frame_i, start_i, enemy_dead_i;
   logic [9:0] enemy_left_i, enemy_right_i, enemy_bot_i;
   logic [9:0] player_left_i, player_right_i, player_top_i, player_bot_i;
   logic       active_o, player_hit_o;
   logic [9:0] left_o, right_o, top_o, bot_o;
   logic [3:0] shot_red_o, shot_green_o, shot_blue_o;

   int n_cmp = 0;
   int n_err = 0;
   int act_cycles = 0;
   int hit_cycles = 0;
   int snap_act, snap_hit;

   always #5 clk = ~clk;

   enemy_shot dut (
      .clk_i          (clk),
      .reset_ni       (reset_ni),
      .frame_i        (frame_i),
      .start_i        (start_i),
      .enemy_dead_i   (enemy_dead_i),
      .enemy_left_i   (enemy_left_i),
      .enemy_right_i  (enemy_right_i),
      .enemy_bot_i    (enemy_bot_i),
      .player_left_i  (player_left_i),
      .player_right_i (player_right_i),
      .player_top_i   (player_top_i),
      .player_bot_i   (player_bot_i),
      .active_o       (active_o),
      .left_o         (left_o),
      .right_o        (right_o),
      .top_o          (top_o),
      .bot_o          (bot_o),
      .player_hit_o   (player_hit_o),
      .shot_red_o     (shot_red_o),
      .shot_green_o   (shot_green_o),
      .shot_blue_o    (shot_blue_o)
   );

   // Count cycles with the bullet visible and with a hit pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (active_o) act_cycles = act_cycles + 1;
      if (player_hit_o) hit_cycles = hit_cycles + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) frame_i = 1'b1;
         @(negedge clk) frame_i = 1'b0;
      end
   endtask

   // Hold frame_i high for n consecutive clocks.
   task automatic burst(input int n);
      @(negedge clk) frame_i = 1'b1;
      repeat (n) @(negedge clk);
      frame_i = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start_i = 1'b1;
      @(negedge clk) start_i = 1'b0;
   endtask

   task automatic player_far();
      player_left_i = 10'd300; player_right_i = 10'd340;
      player_top_i  = 10'd440; player_bot_i   = 10'd459;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_active"}, active_o, 0);
      chk({tag, "_left"}, left_o, 0);
      chk({tag, "_top"}, top_o, 0);
      chk({tag, "_right"}, right_o, 1);
      chk({tag, "_bot"}, bot_o, 7);
      chk({tag, "_hit"}, player_hit_o, 0);
   endtask

   initial begin
      reset_ni = 1'b0; frame_i = 1'b0; start_i = 1'b0; enemy_dead_i = 1'b0;
      enemy_left_i = 10'd100; enemy_right_i = 10'd140; enemy_bot_i = 10'd50;
      player_far();
      #3;
      check_reset_vals("rst0");
      chk("red", shot_red_o, 4'hF);
      chk("green", shot_green_o, 4'h0);
      chk("blue", shot_blue_o, 4'h0);
      repeat (2) @(negedge clk);
      reset_ni = 1'b1;

      // No start: stays idle
      snap_act = act_cycles;
      frames(100);
      chk("idle_no_active", act_cycles - snap_act, 0);

      // Spawn after 60 frames
      pulse_start();
      snap_act = act_cycles;
      frames(59);
      chk("cool59_inactive", act_cycles - snap_act, 0);
      frames(1);
      chk("spawn_active", active_o, 1);
      chk("spawn_left", left_o, 119);
      chk("spawn_right", right_o, 120);
      chk("spawn_top", top_o, 51);
      chk("spawn_bot", bot_o, 58);

      // Flight
      snap_hit = hit_cycles;
      frames(10);
      chk("fly_top", top_o, 91);
      chk("fly_bot", bot_o, 98);
      chk("fly_left", left_o, 119);
      frames(94);
      chk("fly_top467", top_o, 467);
      frames(1);
      chk("fly_top471", top_o, 471);
      chk("fly_bot478", bot_o, 478);
      chk("fly_active471", active_o, 1);
      frames(1);
      chk("off_inactive", active_o, 0);
      chk("off_top_hold", top_o, 471);
      chk("off_no_hit", hit_cycles - snap_hit, 0);

      // Next spawn exactly 60 frames after retirement
      snap_act = act_cycles;
      frames(59);
      chk("respawn59_inactive", act_cycles - snap_act, 0);
      frames(1);
      chk("respawn_active", active_o, 1);
      chk("respawn_top", top_o, 51);

      // Hit: player under the bullet
      player_left_i = 10'd110; player_right_i = 10'd130;
      snap_hit = hit_cycles;
      frames(96);
      chk("hit_pre_top", top_o, 435);
      chk("hit_pre_active", active_o, 1);
      chk("hit_pre_none", hit_cycles - snap_hit, 0);
      frames(1);
      chk("hit_pulse", player_hit_o, 1);
      chk("hit_inactive", active_o, 0);
      chk("hit_top_hold", top_o, 435);
      @(negedge clk);
      chk("hit_pulse_end", player_hit_o, 0);
      chk("hit_once", hit_cycles - snap_hit, 1);
      player_far();

      // Death during cooldown, then start while dead
      enemy_dead_i = 1'b1;
      @(negedge clk);
      pulse_start();
      snap_act = act_cycles;
      frames(200);
      chk("dead_cool_no_spawn", act_cycles - snap_act, 0);
      enemy_dead_i = 1'b0;
      frames(70);
      chk("dead_idle_kept", act_cycles - snap_act, 0);

      // Death during flight: bullet finishes, then idle
      pulse_start();
      frames(60);
      chk("rearm_active", active_o, 1);
      enemy_dead_i = 1'b1;
      burst(5);
      chk("burst_top", top_o, 71);
      frames(100);
      chk("dead_fly_top", top_o, 471);
      chk("dead_fly_active", active_o, 1);
      frames(1);
      chk("dead_fly_done", active_o, 0);
      enemy_dead_i = 1'b0;
      snap_act = act_cycles;
      frames(70);
      chk("dead_fly_idle", act_cycles - snap_act, 0);

      // Asynchronous reset mid-flight
      pulse_start();
      frames(63);
      chk("pre_rst_top", top_o, 63);
      @(negedge clk);
      #2 reset_ni = 1'b0;
      #1;
      check_reset_vals("rst_async");
      @(negedge clk);
      reset_ni = 1'b1;
      snap_act = act_cycles;
      frames(70);
      chk("post_rst_idle", act_cycles - snap_act, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
